// File: rtl/debug_slave_pkg.sv
// Shared types and helpers for the system-clock half of the JTAG debug slave.
// DEBUG_SLAVE_CMD_TIMESTAMP_EN adds a 16-bit timestamp field to each queued command.
package debug_slave_pkg;

  localparam int unsigned TS_W     = 16;
  localparam int unsigned DEF_SR_W = 38;
  localparam int unsigned DEF_IR_W = 2;

  // Bit position of the action flag in a scan register of width sr_w.
  function automatic int unsigned action_bit(input int unsigned sr_w);
    return sr_w - 1;
  endfunction

  typedef struct packed {
    logic [DEF_IR_W-1:0] ir;
    logic [DEF_SR_W-1:0] sr;
`ifdef DEBUG_SLAVE_CMD_TIMESTAMP_EN
    logic [TS_W-1:0]     ts;
`endif
  } cmd_entry_t;

endpackage

// File: rtl/debug_slave_toggle_sync.sv
// Synchronises a TCK-domain toggle into clk and emits a one-cycle pulse per flip.
module debug_slave_toggle_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tgl,
  output logic edge_pulse
);

  // SYNC_STAGES metastability flops plus one history flop for the edge compare.
  logic [SYNC_STAGES:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {(SYNC_STAGES+1){tgl}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-1:0], tgl};
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES] ^ sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/debug_slave_cmd_sync.sv
// Debug slave command path: toggle sync, command FIFO with overflow, per-IR action pulses.
// Optional DEBUG_SLAVE_CMD_TIMESTAMP_EN stores a free-running cycle stamp per entry (cmd_ts).
module debug_slave_cmd_sync
  import debug_slave_pkg::*;
#(
  parameter int unsigned SR_W        = 38,
  parameter int unsigned IR_W        = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          udr_tgl,
  input  logic                          uir_tgl,
  input  logic [IR_W-1:0]               ir_in,
  input  logic [SR_W-1:0]               sr,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [IR_W-1:0]               cmd_ir,
  output logic [SR_W-1:0]               jdo,
  output logic [2**IR_W-1:0]            take_action,
  output logic [2**IR_W-1:0]            take_no_action,
  output logic                          ir_update,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          overflow_clr
`ifdef DEBUG_SLAVE_CMD_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]               cmd_ts
`endif
);

  localparam int unsigned AW         = $clog2(FIFO_DEPTH);
  localparam int unsigned NCH        = 2**IR_W;
  localparam int unsigned ACTION_BIT = action_bit(SR_W);

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] sr;
`ifdef DEBUG_SLAVE_CMD_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
`endif
  } entry_t;

  logic           udr_edge;
  logic           uir_edge;
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [AW:0]    wr_ptr_nxt;
  logic [AW:0]    rd_ptr_nxt;
  logic           full;
  logic           pop;
  logic           push_ok;
  logic           drop;
  entry_t         mem [FIFO_DEPTH];
  entry_t         new_entry;
  entry_t         head_q;
  entry_t         head_nxt;
  logic [NCH-1:0] onehot;

`ifdef DEBUG_SLAVE_CMD_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
    end
  end

  assign cmd_ts = head_q.ts;
`endif

  debug_slave_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk        (clk),
    .reset      (reset),
    .tgl        (udr_tgl),
    .edge_pulse (udr_edge)
  );

  debug_slave_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk        (clk),
    .reset      (reset),
    .tgl        (uir_tgl),
    .edge_pulse (uir_edge)
  );

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(FIFO_DEPTH));
  assign pop     = cmd_valid & cmd_ready & ~reset;
  assign push_ok = udr_edge & (~full | pop);
  assign drop    = udr_edge & full & ~pop;

  assign wr_ptr_nxt = wr_ptr + (AW+1)'(push_ok);
  assign rd_ptr_nxt = rd_ptr + (AW+1)'(pop);

  always_comb begin
    new_entry    = '0;
    new_entry.ir = ir_in;
    new_entry.sr = sr;
`ifdef DEBUG_SLAVE_CMD_TIMESTAMP_EN
    new_entry.ts = ts_cnt;
`endif
  end

  // The head register is loaded with whatever will be at the front after this
  // cycle's push/pop; a push into an empty queue lands here directly.
  always_comb begin
    head_nxt = '0;
    if (wr_ptr_nxt == rd_ptr_nxt) begin
      head_nxt = '0;
    end else if (rd_ptr_nxt == wr_ptr) begin
      head_nxt = new_entry;
    end else begin
      head_nxt = mem[rd_ptr_nxt[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr[AW-1:0]] <= new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      head_q    <= '0;
      cmd_valid <= 1'b0;
      overflow  <= 1'b0;
      ir_update <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      head_q    <= head_nxt;
      cmd_valid <= (wr_ptr_nxt != rd_ptr_nxt);
      ir_update <= uir_edge;
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign cmd_ir = head_q.ir;
  assign jdo    = head_q.sr;

  always_comb begin
    onehot         = '0;
    onehot[cmd_ir] = 1'b1;
    take_action    = '0;
    take_no_action = '0;
    if (pop) begin
      if (jdo[ACTION_BIT]) begin
        take_action = onehot;
      end else begin
        take_no_action = onehot;
      end
    end
  end

endmodule

// File: tb/tb_debug_slave_cmd_sync.sv
// Self-checking bench for debug_slave_cmd_sync against a queue-based command model.
module tb_debug_slave_cmd_sync;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        udr_tgl = 1'b0;
  logic        uir_tgl = 1'b0;
  logic [1:0]  ir_in = '0;
  logic [37:0] sr = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [1:0]  cmd_ir;
  logic [37:0] jdo;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic        ir_update;
  logic [2:0]  level;
  logic        overflow;
  logic        overflow_clr = 1'b0;
`ifdef DEBUG_SLAVE_CMD_TIMESTAMP_EN
  logic [15:0] cmd_ts;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned due;
    logic [1:0]  ir;
    logic [37:0] sr;
  } sched_t;

  typedef struct {
    logic [1:0]  ir;
    logic [37:0] sr;
  } ent_t;

  int unsigned edge_n = 0;
  sched_t      sched_q[$];
  int unsigned uir_q[$];
  ent_t        mq[$];
  bit          ovf_m = 1'b0;
  bit          exp_iru = 1'b0;

  debug_slave_cmd_sync #(
    .SR_W        (38),
    .IR_W        (2),
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .udr_tgl        (udr_tgl),
    .uir_tgl        (uir_tgl),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_ir         (cmd_ir),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .ir_update      (ir_update),
    .level          (level),
    .overflow       (overflow),
    .overflow_clr   (overflow_clr)
`ifdef DEBUG_SLAVE_CMD_TIMESTAMP_EN
    ,
    .cmd_ts         (cmd_ts)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_pulse(input bit want_action);
    logic [3:0] p;
    p = '0;
    if (mq.size() != 0 && cmd_ready && !reset && (mq[0].sr[37] == want_action))
      p[mq[0].ir] = 1'b1;
    return p;
  endfunction

  function automatic logic [37:0] rnd_sr(input bit act);
    logic [36:0] r;
    r = 37'({$urandom(), $urandom()});
    return {act, r};
  endfunction

  // A raw flip is seen as a command three clock edges later.
  task automatic advance();
    bit   pop_m;
    bit   push_due;
    bit   drop;
    bit   was_full;
    ent_t e;
    pop_m = (mq.size() != 0) && cmd_ready && !reset;
    @(posedge clk);
    edge_n++;
    if (reset) begin
      mq.delete();
      sched_q.delete();
      uir_q.delete();
      ovf_m   = 1'b0;
      exp_iru = 1'b0;
    end else begin
      push_due = 1'b0;
      drop     = 1'b0;
      if (sched_q.size() != 0 && sched_q[0].due == edge_n) begin
        push_due = 1'b1;
        e.ir = sched_q[0].ir;
        e.sr = sched_q[0].sr;
        void'(sched_q.pop_front());
      end
      exp_iru = 1'b0;
      while (uir_q.size() != 0 && uir_q[0] == edge_n) begin
        exp_iru = 1'b1;
        void'(uir_q.pop_front());
      end
      was_full = (mq.size() == DEPTH);
      if (pop_m) void'(mq.pop_front());
      if (push_due) begin
        if (!was_full || pop_m) mq.push_back(e);
        else drop = 1'b1;
      end
      if (drop) ovf_m = 1'b1;
      else if (overflow_clr) ovf_m = 1'b0;
    end
    #1;
  endtask

  task automatic flip_udr(input logic [1:0] ir, input logic [37:0] d);
    sched_t s;
    ir_in   = ir;
    sr      = d;
    udr_tgl = ~udr_tgl;
    s.due = edge_n + 3;
    s.ir  = ir;
    s.sr  = d;
    sched_q.push_back(s);
  endtask

  task automatic flip_uir();
    uir_tgl = ~uir_tgl;
    uir_q.push_back(edge_n + 3);
  endtask

  task automatic send(input logic [1:0] ir, input logic [37:0] d);
    flip_udr(ir, d);
    repeat (4) advance();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    advance();
    advance();
    udr_tgl = 1'b1;
    repeat (3) advance();
    checks++;
    if (cmd_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0 || ir_update !== 1'b0) begin
      errors++;
      $display("FAIL reset_state valid=%b level=%0d ovf=%b iru=%b required 0/0/0/0",
               cmd_valid, level, overflow, ir_update);
    end
    checks++;
    if (jdo !== '0 || cmd_ir !== '0 || take_action !== '0 || take_no_action !== '0) begin
      errors++;
      $display("FAIL reset_data jdo=%h ir=%h ta=%b tna=%b required zeros",
               jdo, cmd_ir, take_action, take_no_action);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      advance();
      checks++;
      if (cmd_valid !== 1'b0 || level !== 3'd0) begin
        errors++;
        $display("FAIL reset_release cyc=%0d valid=%b level=%0d required 0/0", i, cmd_valid, level);
      end
    end
  endtask

  task automatic test_single(input logic [1:0] ir, input bit act, input string nm);
    logic [37:0] d;
    logic [3:0]  oh;
    d  = rnd_sr(act);
    oh = '0;
    oh[ir] = 1'b1;
    cmd_ready = 1'b1;
    flip_udr(ir, d);
    for (int c = 1; c <= 5; c++) begin
      advance();
      checks++;
      if (cmd_valid !== (c == 3)) begin
        errors++;
        $display("FAIL %s_latency c=%0d valid=%b required %b", nm, c, cmd_valid, (c == 3));
      end
      checks++;
      if (take_action !== ((c == 3 && act) ? oh : 4'b0) ||
          take_no_action !== ((c == 3 && !act) ? oh : 4'b0)) begin
        errors++;
        $display("FAIL %s_pulse c=%0d ta=%b tna=%b required %b/%b", nm, c, take_action, take_no_action,
                 (c == 3 && act) ? oh : 4'b0, (c == 3 && !act) ? oh : 4'b0);
      end
      if (c == 3) begin
        checks++;
        if (jdo !== d || cmd_ir !== ir) begin
          errors++;
          $display("FAIL %s_data jdo=%h ir=%h required %h/%h", nm, jdo, cmd_ir, d, ir);
        end
      end
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_action();
    test_single(2'b01, 1'b1, "action");
  endtask

  task automatic test_no_action();
    test_single(2'b11, 1'b0, "no_action");
  endtask

  task automatic test_overflow();
    ent_t sent[5];
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sent[i].ir = 2'($urandom_range(0, 3));
      sent[i].sr = rnd_sr(1'($urandom_range(0, 1)));
      send(sent[i].ir, sent[i].sr);
    end
    checks++;
    if (level !== 3'd4 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_fill level=%0d ovf=%b required 4/1", level, overflow);
    end
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (cmd_valid !== 1'b1 || jdo !== sent[i].sr || cmd_ir !== sent[i].ir) begin
        errors++;
        $display("FAIL overflow_order i=%0d valid=%b jdo=%h ir=%h required 1/%h/%h",
                 i, cmd_valid, jdo, cmd_ir, sent[i].sr, sent[i].ir);
      end
      advance();
    end
    checks++;
    if (cmd_valid !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL overflow_fifth valid=%b level=%0d required 0/0", cmd_valid, level);
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    overflow_clr = 1'b1;
    advance();
    overflow_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear ovf=%b required 0", overflow);
    end
    for (int i = 0; i < 4; i++) send(2'($urandom_range(0, 3)), rnd_sr(1'($urandom_range(0, 1))));
    flip_udr(2'b10, rnd_sr(1'b1));
    advance();
    advance();
    cmd_ready = 1'b1;
    #1;
    checks++;
    if ((take_action | take_no_action) !== (exp_pulse(1'b1) | exp_pulse(1'b0)) ||
        (take_action | take_no_action) === 4'b0) begin
      errors++;
      $display("FAIL full_pop_pulse ta=%b tna=%b required %b/%b",
               take_action, take_no_action, exp_pulse(1'b1), exp_pulse(1'b0));
    end
    advance();
    cmd_ready = 1'b0;
    checks++;
    if (level !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop level=%0d ovf=%b required 4/0", level, overflow);
    end
    flip_udr(2'b00, rnd_sr(1'b0));
    advance();
    advance();
    overflow_clr = 1'b1;
    advance();
    overflow_clr = 1'b0;
    checks++;
    if (overflow !== 1'b1 || level !== 3'd4) begin
      errors++;
      $display("FAIL set_wins ovf=%b level=%0d required 1/4", overflow, level);
    end
    overflow_clr = 1'b1;
    advance();
    overflow_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_alone ovf=%b required 0", overflow);
    end
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (mq.size() == 0 || jdo !== mq[0].sr || cmd_ir !== mq[0].ir) begin
        errors++;
        $display("FAIL full_drain i=%0d jdo=%h ir=%h model_size=%0d", i, jdo, cmd_ir, mq.size());
      end
      advance();
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_ir_update();
    int pulses;
`ifdef DEBUG_SLAVE_CMD_TIMESTAMP_EN
    logic [15:0] ts0;
`endif
    cmd_ready = 1'b0;
    send(2'b01, rnd_sr(1'b1));
    send(2'b10, rnd_sr(1'b0));
    flip_uir();
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      advance();
      if (ir_update === 1'b1) pulses++;
      checks++;
      if (ir_update !== exp_iru) begin
        errors++;
        $display("FAIL ir_update_timing c=%0d got=%b required %b", c, ir_update, exp_iru);
      end
    end
    checks++;
    if (pulses != 1 || level !== 3'd2) begin
      errors++;
      $display("FAIL ir_update_count pulses=%0d level=%0d required 1/2", pulses, level);
    end
`ifdef DEBUG_SLAVE_CMD_TIMESTAMP_EN
    ts0 = cmd_ts;
    cmd_ready = 1'b1;
    advance();
    cmd_ready = 1'b0;
    checks++;
    if (cmd_ts - ts0 !== 16'd4) begin
      errors++;
      $display("FAIL ts_increase first=%0d second=%0d required difference 4", ts0, cmd_ts);
    end
`endif
    cmd_ready = 1'b1;
    repeat (3) advance();
    cmd_ready = 1'b0;
  endtask

  task automatic test_random();
    int unsigned cool;
    cool = 0;
    for (int i = 0; i < 600; i++) begin
      cmd_ready    = ($urandom_range(0, 3) < ((i < 300) ? 1 : 3));
      overflow_clr = ($urandom_range(0, 7) == 0);
      reset        = ($urandom_range(0, 149) == 0);
      if (cool == 0 && $urandom_range(0, 2) == 0) begin
        flip_udr(2'($urandom_range(0, 3)), rnd_sr(1'($urandom_range(0, 1))));
        cool = 4;
      end else if (cool > 0) begin
        cool--;
      end
      if ($urandom_range(0, 4) == 0) flip_uir();
      #1;
      checks++;
      if (cmd_valid !== (mq.size() != 0) || level !== 3'(mq.size())) begin
        errors++;
        $display("FAIL rnd_occupancy i=%0d valid=%b level=%0d required %b/%0d",
                 i, cmd_valid, level, (mq.size() != 0), mq.size());
      end
      checks++;
      if (take_action !== exp_pulse(1'b1) || take_no_action !== exp_pulse(1'b0)) begin
        errors++;
        $display("FAIL rnd_pulse i=%0d ta=%b tna=%b required %b/%b",
                 i, take_action, take_no_action, exp_pulse(1'b1), exp_pulse(1'b0));
      end
      if (mq.size() != 0) begin
        checks++;
        if (jdo !== mq[0].sr || cmd_ir !== mq[0].ir) begin
          errors++;
          $display("FAIL rnd_head i=%0d jdo=%h ir=%h required %h/%h", i, jdo, cmd_ir, mq[0].sr, mq[0].ir);
        end
      end
      advance();
      checks++;
      if (overflow !== ovf_m || ir_update !== exp_iru) begin
        errors++;
        $display("FAIL rnd_flags i=%0d ovf=%b iru=%b required %b/%b", i, overflow, ir_update, ovf_m, exp_iru);
      end
    end
    reset        = 1'b0;
    overflow_clr = 1'b0;
    cmd_ready    = 1'b0;
  endtask

  initial begin
    test_reset();
    test_action();
    test_no_action();
    test_overflow();
    test_full_pop();
    test_ir_update();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
